sr_latch_arbiter: RTL and testbench
===================================

Name: sr_latch_arbiter

Overview:
- Synchronous controller that shares one SR latch among N_REQ requesters. Each requester asks to set or clear the latch.
- The block arbitrates round-robin and drives the latch s/r inputs with a timed pulse followed by a settle gap. It then checks the latch q output and acknowledges the winner.
- It guarantees that s and r are never asserted together, so the latch never enters its forbidden s=r=1 input state. It sits between the requester logic and a bare sr_latch instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PULSE_LEN, 2, cycles s or r is held high (>=1).
- GAP_LEN, 2, cycles with s=r=0 after the pulse, before q is sampled (>=1).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  req[i]=1: requester i wants an operation. Held until ack[i].
- op  input  N_REQ  op[i]=1 set, 0 clear. Must be stable while req[i]=1.
- q  input  1  latch output feedback.
- s  output  1  latch set input, registered.
- r  output  1  latch reset input, registered.
- ack  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- ok  output  1  valid only while ack!=0. 1 when the sampled q matches the requested op.
- busy  output  1  1 in every state except IDLE.

Behaviour:
- Reset values: s=0, r=0, ack=0, ok=0, busy=0, state=IDLE, round-robin pointer ptr=0, counter=0. Reset has priority over everything, including mid-operation. If reset is high at an edge, s and r are 0 after that edge and the in-flight operation is dropped with no ack.
- States: IDLE, PULSE, GAP, ACK.
- IDLE, no req: stay in IDLE.
- IDLE, with req: grant g = first i with req[i]=1, scanning ptr, ptr+1, ... modulo N_REQ.
  - Register g and op_r = op[g]. Set ptr = (g+1) mod N_REQ.
  - Skip case: if q === op_r (q is 4-state-equal to op_r, so X never matches), go directly to ACK with ok_r=1. No pulse is issued.
  - Otherwise go to PULSE: s=op_r, r=~op_r, cnt=PULSE_LEN-1.
- PULSE: hold s/r. When cnt=0, set s=r=0, load cnt=GAP_LEN-1, and go to GAP. Otherwise decrement cnt.
- GAP: s=r=0. When cnt=0, set ok_r = (q === op_r) and go to ACK. Otherwise decrement cnt.
- ACK, for exactly one cycle: ack[g]=1, ok=ok_r, busy=1. Then go to IDLE.
- Latency with a pulse: req sampled in IDLE at edge T.
  - s or r is high during cycles T+1 .. T+PULSE_LEN.
  - Both are low for the next GAP_LEN cycles.
  - ack is high in cycle T+PULSE_LEN+GAP_LEN+1.
  - The earliest next grant is at the edge that ends IDLE, at T+PULSE_LEN+GAP_LEN+2.
- Latency in the skip case: ack is high in cycle T+1.
- Invariants, every cycle: s&r == 0; at most one ack bit set; ack!=0 only in ACK; ok=0 whenever ack=0.
- req[g] dropped mid-operation: the operation still completes and ack still pulses.
- op[g] changing mid-operation: ignored; op_r is used.
- req[g] still high after ack: treated as a new request. Round-robin rotation means other pending requesters are served first.
- All req bits low in IDLE: outputs stay at their reset values. ptr is unchanged.
- ptr wraps from N_REQ-1 to 0.

Test Plan:
- Reset, then q=0, req=4'b0001, op=4'b0001 → s=1 for 2 cycles, s=r=0 for 2 cycles, then ack=4'b0001 with ok=1 (model q=1 after s). busy is high for 5 cycles.
- Skip case: q=1, req=4'b0010, op=4'b0010 → no s/r pulse; ack=4'b0010 and ok=1 one cycle after the request is sampled.
- Fairness: req=4'b1111 held, op alternating, ack each time → grants in order 0,1,2,3,0. ptr wraps correctly. s&r never both 1.
- Stuck latch: q forced to 0, set requested → full pulse and gap, then ack with ok=0.
- Reset mid-PULSE with s=1 → s=0, busy=0, ack stays 0. The next req=4'b0100 is granted to index 2 (ptr=0 after reset, so the scan starts at 0).
- req[3] dropped during GAP → ack[3] still pulses once. The next state is IDLE with no spurious grant.

Source files
------------

// File: rtl/sr_latch_arbiter_if.sv
// Requester-side handshake bundle for sr_latch_arbiter.
// The requester logic drives req/op and observes ack/ok/busy.
interface sr_latch_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] op;
   logic [N_REQ-1:0] ack;
   logic             ok;
   logic             busy;

   // Requester side: issues operations, watches completion.
   modport master (
      output req,
      output op,
      input  ack,
      input  ok,
      input  busy
   );

   // Arbiter side: consumes operations, reports completion.
   modport slave (
      input  req,
      input  op,
      output ack,
      output ok,
      output busy
   );
endinterface

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter sharing one bare SR latch among N_REQ requesters.
// A winner's set/clear request becomes a PULSE_LEN-cycle pulse on s or r,
// followed by a GAP_LEN-cycle quiet period, after which q is sampled and
// the winner gets a one-cycle ack with ok = (q matches the request).
// s and r are both derived from a single registered op bit, so they can
// never be high together. If q already holds the requested value the
// pulse is skipped and the ack is issued on the next cycle.
module sr_latch_arbiter #(
   parameter int N_REQ     = 4,
   parameter int PULSE_LEN = 2,
   parameter int GAP_LEN   = 2
) (
   input  logic              clock,
   input  logic              reset,
   sr_latch_arbiter_if.slave bus,
   input  logic              q,
   output logic              s,
   output logic              r
);

   localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW1     = PW + 1;
   localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);
   localparam logic [PW-1:0] LAST_IDX   = PW'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_ACK   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    ptr_q,   ptr_d;
   logic [PW-1:0]    gnt_q,   gnt_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             op_q,    op_d;
   logic             s_q,     s_d;
   logic             r_q,     r_d;
   logic [N_REQ-1:0] ack_q,   ack_d;
   logic             ok_q,    ok_d;
   logic             busy_q,  busy_d;

   logic [PW:0]      pick_s;
   logic [PW-1:0]    win_idx_s;
   logic             win_vld_s;
   logic             win_op_s;

   // Round-robin pick: first requester at or after start, wrapping.
   // Result is {found, index}.
   function automatic logic [PW:0] rr_pick(
      input logic [N_REQ-1:0] req_v,
      input logic [PW-1:0]    start
   );
      logic [PW:0] res;
      logic [PW:0] sum;
      res = {1'b0, start};
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, start} + PW1'(k);
         if (sum >= PW1'(N_REQ)) begin
            sum = sum - PW1'(N_REQ);
         end else begin
            sum = sum;
         end
         if (!res[PW] && req_v[sum[PW-1:0]]) begin
            res = {1'b1, sum[PW-1:0]};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // One-hot ack vector for a granted index.
   function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Pointer following a grant, wrapping after the last requester.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
      logic [PW-1:0] n;
      if (idx == LAST_IDX) begin
         n = '0;
      end else begin
         n = idx + PW'(1);
      end
      return n;
   endfunction

   // Candidate winner for the current cycle (used only in IDLE).
   always_comb begin
      pick_s    = rr_pick(bus.req, ptr_q);
      win_vld_s = pick_s[PW];
      win_idx_s = pick_s[PW-1:0];
      win_op_s  = bus.op[win_idx_s];
   end

   // Next-state and registered-output logic for the IDLE/PULSE/GAP/ACK sequence.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      s_d     = 1'b0;
      r_d     = 1'b0;
      ack_d   = '0;
      ok_d    = 1'b0;
      busy_d  = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (win_vld_s) begin
               gnt_d = win_idx_s;
               op_d  = win_op_s;
               ptr_d = next_ptr(win_idx_s);
               // Four-state compare: an unknown q never counts as matching.
               if (q === win_op_s) begin
                  state_d = ST_ACK;
                  ack_d   = onehot(win_idx_s);
                  ok_d    = 1'b1;
               end else begin
                  state_d = ST_PULSE;
                  s_d     = win_op_s;
                  r_d     = ~win_op_s;
                  cnt_d   = PULSE_LOAD;
               end
            end else begin
               busy_d = 1'b0;
            end
         end

         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
               s_d   = op_q;
               r_d   = ~op_q;
            end
         end

         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
               ack_d   = onehot(gnt_q);
               ok_d    = (q === op_q);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_ACK: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight operation.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         ack_q   <= '0;
         ok_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         s_q     <= s_d;
         r_q     <= r_d;
         ack_q   <= ack_d;
         ok_q    <= ok_d;
         busy_q  <= busy_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign bus.ack  = ack_q;
   assign bus.ok   = ok_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Directed bench for sr_latch_arbiter (N_REQ=4, PULSE_LEN=2, GAP_LEN=2)
// driving a behavioural SR latch whose q can also be forced 0 or 1.
module tb_sr_latch_arbiter;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic       s;
   logic       r;
   wire        q;
   logic       q_lat  = 1'b0;
   logic [1:0] q_mode = 2'd0;   // 0: latch, 1: forced 0, 2: forced 1
   int         n_vec  = 0;
   int         n_err  = 0;

   sr_latch_arbiter_if #(.N_REQ(4)) bus_if ();

   sr_latch_arbiter #(
      .N_REQ(4),
      .PULSE_LEN(2),
      .GAP_LEN(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus_if),
      .q(q),
      .s(s),
      .r(r)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Behavioural SR latch fed by the DUT.
   always @(s or r) begin
      if (s && !r) begin
         q_lat = 1'b1;
      end else if (r && !s) begin
         q_lat = 1'b0;
      end else begin
         q_lat = q_lat;
      end
   end

   assign q = (q_mode == 2'd1) ? 1'b0 : ((q_mode == 2'd2) ? 1'b1 : q_lat);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Clock until ack appears (bounded), tallying s/r/busy cycles and invariant breaks.
   task automatic wait_ack(input string tag, input logic [3:0] exp_ack, input logic exp_ok,
                           input int exp_lat, input int exp_s, input int exp_r, input int exp_busy);
      int         lat;
      int         s_cnt;
      int         r_cnt;
      int         b_cnt;
      int         bad;
      logic [3:0] got_ack;
      logic       got_ok;
      lat = 0; s_cnt = 0; r_cnt = 0; b_cnt = 0; bad = 0;
      got_ack = 4'b0000; got_ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s) s_cnt++;
         if (r) r_cnt++;
         if (bus_if.busy) b_cnt++;
         if (s && r) bad++;
         if ((bus_if.ack == 4'b0000) && bus_if.ok) bad++;
         if ($countones(bus_if.ack) > 1) bad++;
         if (bus_if.ack != 4'b0000) begin
            lat     = i + 1;
            got_ack = bus_if.ack;
            got_ok  = bus_if.ok;
            break;
         end
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " ack"}, got_ack, exp_ack);
      chk({tag, " ok"}, got_ok, exp_ok);
      chk({tag, " s cycles"}, s_cnt, exp_s);
      chk({tag, " r cycles"}, r_cnt, exp_r);
      chk({tag, " busy cycles"}, b_cnt, exp_busy);
      chk({tag, " invariants"}, bad, 0);
   endtask

   initial begin
      int quiet;
      bus_if.req = 4'b0000;
      bus_if.op  = 4'b0000;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("reset s", s, 1'b0);
      chk("reset r", r, 1'b0);
      chk("reset ack", bus_if.ack, 4'b0000);
      chk("reset ok", bus_if.ok, 1'b0);
      chk("reset busy", bus_if.busy, 1'b0);
      reset = 1'b0;

      // Set from q=0: 2-cycle s pulse, 2-cycle gap, ack in cycle T+5
      q_mode     = 2'd0;
      bus_if.req = 4'b0001;
      bus_if.op  = 4'b0001;
      wait_ack("set0", 4'b0001, 1'b1, 5, 2, 0, 5);
      bus_if.req = 4'b0000;
      tick();
      chk("set0 idle busy", bus_if.busy, 1'b0);
      chk("set0 idle ack", bus_if.ack, 4'b0000);

      // Skip case: q already 1, ptr=1
      q_mode     = 2'd2;
      bus_if.req = 4'b0010;
      bus_if.op  = 4'b0010;
      wait_ack("skip1", 4'b0010, 1'b1, 1, 0, 0, 1);
      bus_if.req = 4'b0000;
      tick();

      // Fairness from ptr=0 with all requesters held, latch q=1 initially
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q_mode     = 2'd0;
      bus_if.req = 4'b1111;
      bus_if.op  = 4'b1010;
      wait_ack("rr g0", 4'b0001, 1'b1, 5, 0, 2, 5);
      wait_ack("rr g1", 4'b0010, 1'b1, 6, 2, 0, 5);
      wait_ack("rr g2", 4'b0100, 1'b1, 6, 0, 2, 5);
      wait_ack("rr g3", 4'b1000, 1'b1, 6, 2, 0, 5);
      wait_ack("rr wrap g0", 4'b0001, 1'b1, 6, 0, 2, 5);
      bus_if.req = 4'b0000;
      tick();
      chk("rr idle busy", bus_if.busy, 1'b0);

      // Stuck latch: q held 0, set requested by 1 (ptr=1)
      q_mode     = 2'd1;
      bus_if.req = 4'b0010;
      bus_if.op  = 4'b0010;
      wait_ack("stuck", 4'b0010, 1'b0, 5, 2, 0, 5);
      bus_if.req = 4'b0000;
      tick();

      // Reset during PULSE
      bus_if.req = 4'b0100;
      bus_if.op  = 4'b0100;
      tick();
      chk("mid pulse s", s, 1'b1);
      reset      = 1'b1;
      bus_if.req = 4'b0000;
      tick();
      chk("mid rst s", s, 1'b0);
      chk("mid rst r", r, 1'b0);
      chk("mid rst busy", bus_if.busy, 1'b0);
      chk("mid rst ack", bus_if.ack, 4'b0000);
      reset = 1'b0;
      quiet = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus_if.ack != 4'b0000) quiet++;
         if (bus_if.busy) quiet++;
      end
      chk("mid rst quiet", quiet, 0);

      // After reset ptr=0: requesters 2 and 3 pending, 2 wins (clear, q_lat=1)
      q_mode     = 2'd0;
      bus_if.req = 4'b1100;
      bus_if.op  = 4'b1000;
      wait_ack("post rst g2", 4'b0100, 1'b1, 5, 0, 2, 5);

      // Requester 3 (set) drops req during GAP; ack still pulses once
      bus_if.req = 4'b1000;
      tick();
      chk("g3 idle busy", bus_if.busy, 1'b0);
      tick();
      chk("g3 pulse s", s, 1'b1);
      tick();
      tick();
      chk("g3 gap s", s, 1'b0);
      chk("g3 gap r", r, 1'b0);
      bus_if.req = 4'b0000;
      tick();
      chk("g3 gap2 ack", bus_if.ack, 4'b0000);
      tick();
      chk("g3 ack", bus_if.ack, 4'b1000);
      chk("g3 ok", bus_if.ok, 1'b1);
      tick();
      chk("g3 after ack", bus_if.ack, 4'b0000);
      chk("g3 after busy", bus_if.busy, 1'b0);
      tick();
      chk("g3 no regrant busy", bus_if.busy, 1'b0);
      chk("g3 no regrant s", s, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
